// File: rtl/coin_acceptor_if.sv
// Sensor/handshake bundle between the coin acceptor and whatever drives it.
// The master side owns the raw sensors and accept_en; the slave side is the acceptor.
interface coin_acceptor_if;
  logic       coin1_raw;
  logic       coin2_raw;
  logic       accept_en;
  logic [1:0] coin_code;
  logic       coin_valid;
  logic       coin_reject;
  logic       jam;
  logic [7:0] coin_total;

  modport master (
    output coin1_raw, coin2_raw, accept_en,
    input  coin_code, coin_valid, coin_reject, jam, coin_total
  );

  modport slave (
    input  coin1_raw, coin2_raw, accept_en,
    output coin_code, coin_valid, coin_reject, jam, coin_total
  );
endinterface

// File: rtl/coin_acceptor.sv
// Debounced two-sensor coin acceptor: synchronises the raw sensors, qualifies a
// single coin, emits a one-cycle coin code, and flags jams and double insertions.
module coin_acceptor #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MIN_GAP         = 2,
  parameter int JAM_CYCLES      = 64
) (
  input  logic          clk,
  input  logic          reset,
  coin_acceptor_if.slave bus
);

  localparam int JW = $clog2(JAM_CYCLES) + 1;
  localparam logic [7:0]    DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]    GAP_LAST = 8'(MIN_GAP - 1);
  localparam logic [JW-1:0] JAM_LAST = JW'(JAM_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, DEBOUNCE, EMIT, WAIT_RELEASE, GAP, JAM
  } state_t;

  logic [1:0] raw;
  logic [1:0] sync;
  logic       s1, s2;

  assign raw = {bus.coin2_raw, bus.coin1_raw};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      logic meta_reg;
      logic sync_reg;
      always_ff @(posedge clk) begin
        if (reset) begin
          meta_reg <= 1'b0;
          sync_reg <= 1'b0;
        end else begin
          meta_reg <= raw[gi];
          sync_reg <= meta_reg;
        end
      end
      assign sync[gi] = sync_reg;
    end
  endgenerate

  assign s1 = sync[0];
  assign s2 = sync[1];

  state_t        state_reg, state_next;
  logic [7:0]    cnt_reg, cnt_next;
  logic [JW-1:0] jam_cnt_reg, jam_cnt_next;
  logic          cand_reg, cand_next;   // 0 = Re.1 sensor, 1 = Rs.2 sensor
  logic          reject_next;
  logic          cand_hi, other_hi;

  logic [1:0] coin_code_reg;
  logic       coin_valid_reg;
  logic       coin_reject_reg;
  logic       jam_reg;
  logic [7:0] total_reg, total_next;
  logic [8:0] total_sum;

  assign cand_hi  = cand_reg ? s2 : s1;
  assign other_hi = cand_reg ? s1 : s2;

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    jam_cnt_next = jam_cnt_reg;
    cand_next    = cand_reg;
    reject_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (s1 && s2) begin
          state_next   = WAIT_RELEASE;
          reject_next  = 1'b1;
          jam_cnt_next = '0;
        end else if (s1 || s2) begin
          if (bus.accept_en) begin
            state_next = DEBOUNCE;
            cand_next  = s2;
            cnt_next   = '0;
          end else begin
            state_next   = WAIT_RELEASE;
            reject_next  = 1'b1;
            jam_cnt_next = '0;
          end
        end
      end
      DEBOUNCE: begin
        // A second sensor during qualification is a double insertion, even if
        // the first one drops in the same cycle.
        if (other_hi) begin
          state_next   = WAIT_RELEASE;
          reject_next  = 1'b1;
          jam_cnt_next = '0;
        end else if (!cand_hi) begin
          state_next = IDLE;
        end else if (cnt_reg == DEB_LAST) begin
          state_next = EMIT;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      EMIT: begin
        state_next   = WAIT_RELEASE;
        jam_cnt_next = '0;
      end
      WAIT_RELEASE: begin
        if (!s1 && !s2) begin
          state_next = GAP;
          cnt_next   = '0;
        end else if (jam_cnt_reg == JAM_LAST) begin
          state_next = JAM;
          cnt_next   = '0;
        end else begin
          jam_cnt_next = jam_cnt_reg + 1'b1;
        end
      end
      GAP: begin
        if (cnt_reg == GAP_LAST) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      JAM: begin
        if (s1 || s2) begin
          cnt_next = '0;
        end else if (cnt_reg == DEB_LAST) begin
          state_next = GAP;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    total_sum  = {1'b0, total_reg} + (cand_reg ? 9'd2 : 9'd1);
    total_next = total_reg;
    if (state_next == EMIT) begin
      total_next = total_sum[8] ? 8'd255 : total_sum[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      jam_cnt_reg     <= '0;
      cand_reg        <= 1'b0;
      coin_code_reg   <= 2'd0;
      coin_valid_reg  <= 1'b0;
      coin_reject_reg <= 1'b0;
      jam_reg         <= 1'b0;
      total_reg       <= 8'd0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      jam_cnt_reg     <= jam_cnt_next;
      cand_reg        <= cand_next;
      coin_code_reg   <= (state_next == EMIT) ? (cand_next ? 2'd2 : 2'd1) : 2'd0;
      coin_valid_reg  <= (state_next == EMIT);
      coin_reject_reg <= reject_next;
      jam_reg         <= (state_next == JAM);
      total_reg       <= total_next;
    end
  end

  assign bus.coin_code   = coin_code_reg;
  assign bus.coin_valid  = coin_valid_reg;
  assign bus.coin_reject = coin_reject_reg;
  assign bus.jam         = jam_reg;
  assign bus.coin_total  = total_reg;

endmodule
